// File: rtl/w0rm_core_alu_writeback.sv
// ALU writeback buffer: captures ALU result pulses into a small FWFT FIFO and
// presents them on a valid/ready port to the register file.
module w0rm_core_alu_writeback #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_result_valid,
  input  logic [3:0]                    alu_flags,
  input  logic [USER_WIDTH-1:0]         alu_user_data,
  output logic                          mem_ready,
  input  logic                          flush,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [DATA_WIDTH-1:0]         wb_data,
  output logic [3:0]                    wb_flags,
  output logic [USER_WIDTH-1:0]         wb_user,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_err
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 4 + USER_WIDTH;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    full = (count == LVL_W'(FIFO_DEPTH));
    pop  = (count != '0) && wb_ready;
    push = alu_result_valid && (!full || pop);
    drop = alu_result_valid && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {alu_result, alu_flags, alu_user_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // One slot of headroom covers a result already in flight inside the ALU.
  always_comb begin
    mem_ready  = (count < LVL_W'(FIFO_DEPTH - 1));
    wb_valid   = (count != '0);
    fifo_level = count;
    {wb_data, wb_flags, wb_user} = mem[rd_ptr];
  end

endmodule
